// File: rtl/pic_pkg.sv
// Shared definitions for the PIC initialization sequencer: FSM states,
// write-command decode and register bit positions.
package pic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CMD_ICW1 = 2'd0,
      CMD_OCW2 = 2'd1,
      CMD_OCW3 = 2'd2,
      CMD_DATA = 2'd3
   } cmd_t;

   // ICW1 byte fields and their packed positions in icw1_cfg {ltim, sngl, ic4}
   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;
   localparam int CFG_IC4   = 0;
   localparam int CFG_SNGL  = 1;
   localparam int CFG_LTIM  = 2;

   // icw4_cfg = {sfnm, buf, ms, aeoi, upm}
   localparam int ICW4_UPM  = 0;
   localparam int ICW4_AEOI = 1;
   localparam int ICW4_MS   = 2;
   localparam int ICW4_BUF  = 3;
   localparam int ICW4_SFNM = 4;

   localparam int OCW3_RIS  = 0;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_POLL = 2;
   localparam int OCW3_SMM  = 5;
   localparam int OCW3_ESMM = 6;

   // sel is bus[4:3]; A1=1 writes are resolved by the FSM state.
   function automatic cmd_t decode_cmd(input logic a1, input logic [1:0] sel);
      if (a1)
         return CMD_DATA;
      else if (sel[1])
         return CMD_ICW1;
      else if (sel[0])
         return CMD_OCW3;
      else
         return CMD_OCW2;
   endfunction

endpackage

// File: rtl/pic_init_sequencer.sv
// 8259-style ICW/OCW write sequencer. Define PIC_CASCADE_EN to enable ICW3
// (cascade) handling; otherwise the device is always treated as single.
module pic_init_sequencer
   import pic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       CS,
   input  logic       wr_enable,
   input  logic       A1,
   input  logic [7:0] internal_bus,
   output logic       write_ICW_1,
   output logic       write_ICW2,
   output logic       write_ICW3,
   output logic       write_ICW4,
   output logic       write_OCW1,
   output logic       write_OCW2,
   output logic       write_OCW3,
   output logic       init_done,
   output logic [2:0] icw1_cfg,
   output logic [4:0] vector_base,
   output logic [7:0] cascade_cfg,
   output logic [4:0] icw4_cfg,
   output logic [7:0] imr,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_level,
   output logic       read_isr_sel,
   output logic       smm,
   output logic       poll
);

   state_t state, state_nxt;
   cmd_t   cmd;
   logic   wr_prev;
   logic   wr_stb;
   logic   sngl_in;
   logic   acc_icw1, acc_data, acc_ocw2, acc_ocw3;

   // A held-low strobe is one write: only the falling sample counts.
   assign wr_stb   = ~CS & wr_prev & ~wr_enable;
   assign cmd      = decode_cmd(A1, internal_bus[4:3]);
   assign acc_icw1 = wr_stb && (cmd == CMD_ICW1);
   assign acc_data = wr_stb && (cmd == CMD_DATA);
   assign acc_ocw2 = wr_stb && (cmd == CMD_OCW2) && (state == ST_READY);
   assign acc_ocw3 = wr_stb && (cmd == CMD_OCW3) && (state == ST_READY);

`ifdef PIC_CASCADE_EN
   assign sngl_in = internal_bus[ICW1_SNGL];
`else
   assign sngl_in = 1'b1;
`endif

   assign init_done = (state == ST_READY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         wr_prev <= 1'b1;
      end else begin
         state   <= state_nxt;
         wr_prev <= wr_enable;
      end
   end

   always_comb begin
      state_nxt = state;
      if (acc_icw1) begin
         state_nxt = ST_WAIT_ICW2;
      end else if (acc_data) begin
         case (state)
            ST_WAIT_ICW2: begin
               if (!icw1_cfg[CFG_SNGL])
                  state_nxt = ST_WAIT_ICW3;
               else if (icw1_cfg[CFG_IC4])
                  state_nxt = ST_WAIT_ICW4;
               else
                  state_nxt = ST_READY;
            end
            ST_WAIT_ICW3: state_nxt = icw1_cfg[CFG_IC4] ? ST_WAIT_ICW4 : ST_READY;
            ST_WAIT_ICW4: state_nxt = ST_READY;
            default:      state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_ICW_1  <= 1'b0;
         write_ICW2   <= 1'b0;
         write_ICW4   <= 1'b0;
         write_OCW1   <= 1'b0;
         write_OCW2   <= 1'b0;
         write_OCW3   <= 1'b0;
         poll         <= 1'b0;
         icw1_cfg     <= 3'd0;
         vector_base  <= 5'd0;
         icw4_cfg     <= 5'd0;
         imr          <= 8'hFF;
         ocw2_cmd     <= 3'd0;
         ocw2_level   <= 3'd0;
         read_isr_sel <= 1'b0;
         smm          <= 1'b0;
      end else begin
         write_ICW_1 <= acc_icw1;
         write_ICW2  <= acc_data && (state == ST_WAIT_ICW2);
         write_ICW4  <= acc_data && (state == ST_WAIT_ICW4);
         write_OCW1  <= acc_data && (state == ST_READY);
         write_OCW2  <= acc_ocw2;
         write_OCW3  <= acc_ocw3;
         poll        <= acc_ocw3 && internal_bus[OCW3_POLL];

         if (acc_icw1) begin
            icw1_cfg     <= {internal_bus[ICW1_LTIM], sngl_in, internal_bus[ICW1_IC4]};
            imr          <= 8'h00;
            icw4_cfg     <= 5'd0;
            smm          <= 1'b0;
            read_isr_sel <= 1'b0;
         end
         if (acc_data && (state == ST_WAIT_ICW2))
            vector_base <= internal_bus[7:3];
         if (acc_data && (state == ST_WAIT_ICW4))
            icw4_cfg <= internal_bus[4:0];
         if (acc_data && (state == ST_READY))
            imr <= internal_bus;
         if (acc_ocw2) begin
            ocw2_cmd   <= internal_bus[7:5];
            ocw2_level <= internal_bus[2:0];
         end
         if (acc_ocw3) begin
            if (internal_bus[OCW3_RR])
               read_isr_sel <= internal_bus[OCW3_RIS];
            if (internal_bus[OCW3_ESMM])
               smm <= internal_bus[OCW3_SMM];
         end
      end
   end

`ifdef PIC_CASCADE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_ICW3  <= 1'b0;
         cascade_cfg <= 8'd0;
      end else begin
         write_ICW3 <= acc_data && (state == ST_WAIT_ICW3);
         if (acc_data && (state == ST_WAIT_ICW3))
            cascade_cfg <= internal_bus;
      end
   end
`else
   assign write_ICW3  = 1'b0;
   assign cascade_cfg = 8'd0;
`endif

endmodule
